// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory between fetch and decode.
// Latency: one cycle from an accepted request to rsp_valid. Throughput is one fetch per cycle.
// Backpressure: req_ready drops while a response is held and rsp_ready is low.
//   It is also low during the post-reset NOP sweep.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  fetch handshake; req_addr is a byte address
//   rsp_valid/rsp_ready  response handshake; rsp_instr and rsp_fault are registered
//   rsp_fault            bit0 = misaligned, bit1 = out of range
//   load_we/load_idx/load_data  program-load write port (RUN state only, no handshake)
//   busy                 high while the memory is being swept to NOP_WORD
//
// Optional feature: define IMEM_MISALIGN_TRAP_EN to fault requests with req_addr[1:0] != 0.
// Without it, the low address bits are ignored and rsp_fault[0] is always 0.
module instr_mem_sync #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 256,
    parameter logic [INSTR_W-1:0] NOP_WORD = 32'h00000013,
    localparam int                IDX_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [1:0]         rsp_fault,
    input  logic               load_we,
    input  logic [IDX_W-1:0]   load_idx,
    input  logic [INSTR_W-1:0] load_data,
    output logic               busy
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   cnt_d;

    logic [INSTR_W-1:0] mem [DEPTH];

    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [INSTR_W-1:0] mem_wdata;

    logic               accept;
    logic               out_of_range;
    logic               misaligned;
    logic               bypass;
    logic [IDX_W-1:0]   rd_idx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshake outputs, and memory write-port mux.
    // In INIT the sweep owns the write port and the load port is ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_widx  = load_idx;
        mem_wdata = load_data;
        case (state_q)
            ST_INIT: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_widx  = cnt_q;
                mem_wdata = NOP_WORD;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we    = load_we;
                // A drain and a new accept may happen on the same edge.
                req_ready = !rsp_valid || rsp_ready;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage array. It has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Address decode. The range check compares the whole word-address field,
    // so high address bits can never alias into the array.
    assign accept       = req_valid && req_ready;
    assign rd_idx       = req_addr[IDX_W+1:2];
    assign out_of_range = (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));

`ifdef IMEM_MISALIGN_TRAP_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    // The byte offset floors to the containing word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign misaligned      = 1'b0;
`endif

    // Write-first: a load landing on the word being fetched this edge is returned.
    assign bypass = (state_q == ST_RUN) && load_we && (load_idx == rd_idx);

    // Response register. It holds while stalled and clears on a drain with no new accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_instr <= NOP_WORD;
            rsp_fault <= 2'b00;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= {out_of_range, misaligned};
            if (out_of_range || misaligned) begin
                rsp_instr <= NOP_WORD;
            end else if (bypass) begin
                rsp_instr <= load_data;
            end else begin
                rsp_instr <= mem[rd_idx];
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: scoreboard bench for instr_mem_sync.
// Stimulus issues fetches and loads; a word-array model pushes expected responses.
// A negedge monitor compares the DUT output against the head of the expected queue.
module tb_instr_mem_sync;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        load_we;
    logic [7:0]  load_idx;
    logic [31:0] load_data;
    logic        busy;

    instr_mem_sync dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .load_we   (load_we),
        .load_idx  (load_idx),
        .load_data (load_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          started = 1'b0;

    // Reference model: word array, init countdown, and pending-response queue.
    logic [31:0] ref_mem [DEPTH];
    int          init_left = DEPTH;
    logic [33:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] expect_rsp(input logic [63:0] a);
        logic [61:0] word;
        logic [1:0]  f;
        logic [31:0] ins;
        word = a >> 2;
        f    = 2'b00;
        if (word >= 62'(DEPTH)) f[1] = 1'b1;
`ifdef IMEM_MISALIGN_TRAP_EN
        if (a[1:0] != 2'b00) f[0] = 1'b1;
`endif
        if (f != 2'b00) ins = NOP;
        else            ins = ref_mem[word % DEPTH];
        return {ins, f};
    endfunction

    // Model update on every active edge; inputs are stable here because the driver
    // changes them #1 after the edge. The monitor has already popped any drained entry.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
            init_left = DEPTH;
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            if (load_we) ref_mem[load_idx] = load_data;
            if (req_valid && exp_q.size() == 0) exp_q.push_back(expect_rsp(req_addr));
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [33:0] head;
        if (started) begin
            check("busy", busy, init_left > 0);
            check("rsp_valid", rsp_valid, exp_q.size() != 0);
            check("req_ready", req_ready, (init_left == 0) && (exp_q.size() == 0 || rsp_ready));
            if (rsp_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                check("rsp_instr", rsp_instr, head[33:2]);
                check("rsp_fault", rsp_fault, head[1:0]);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the current request until it is accepted, then returns just after the accepting edge.
    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 1000) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: got no req_ready, expected one within 1000 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [63:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] d);
        load_we   = 1'b1;
        load_idx  = idx;
        load_data = d;
        tick();
        load_we   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [63:0] a;
        logic [31:0] prog [4];
        prog[0] = 32'h00700013;
        prog[1] = 32'h07600993;
        prog[2] = 32'h00100593;
        prog[3] = 32'h00B98B33;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        load_we = 1'b0; load_idx = '0; load_data = '0;
        tick();
        started = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_instr", rsp_instr, NOP);
        check("reset_rsp_fault", rsp_fault, 0);
        check("reset_busy", busy, 1);
        check("reset_req_ready", req_ready, 0);

        // Hold a request through the sweep and count the not-ready cycles.
        tick();
        reset = 1'b0; req_valid = 1'b1; req_addr = 64'd0;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready || n > 2000) break;
            n++;
        end
        check("init_cycles", n, DEPTH);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("first_fetch_nop", rsp_instr, NOP);

        // Load a small program and fetch it back-to-back.
        tick();
        for (int i = 0; i < 4; i++) load(8'(i), prog[i]);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 64'(i * 4);
            wait_accept();
        end
        req_valid = 1'b0;
        repeat (2) tick();

        // Stall the response and hold a second request until the drain.
        rsp_ready = 1'b0;
        fetch(64'd4);
        req_valid = 1'b1; req_addr = 64'd8;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold_instr", rsp_instr, prog[1]);
            check("stall_req_ready", req_ready, 0);
        end
        tick();
        rsp_ready = 1'b1;
        #1;
        check("drain_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        repeat (2) tick();

        // A load and a fetch of the same word on the same edge.
        load_we = 1'b1; load_idx = 8'd10; load_data = 32'h00D50663;
        req_valid = 1'b1; req_addr = 64'd40;
        wait_accept();
        load_we = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("bypass_instr", rsp_instr, 32'h00D50663);

        // Fault cases.
        tick();
        fetch(64'd1024);
        @(negedge clk);
        check("oor_instr", rsp_instr, NOP);
        check("oor_fault", rsp_fault, 2'b10);
        tick();
        fetch(64'hFFFF_FFFF_0000_0000);
        fetch(64'd2);
        @(negedge clk);
`ifdef IMEM_MISALIGN_TRAP_EN
        check("misalign_instr", rsp_instr, NOP);
        check("misalign_fault", rsp_fault, 2'b01);
`else
        check("floor_instr", rsp_instr, prog[0]);
        check("floor_fault", rsp_fault, 2'b00);
`endif
        tick();
        fetch(64'd1027);

        // Random traffic with loads, stalls, and faulting addresses.
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom % 3) != 0;
            rsp_ready = ($urandom % 4) != 0;
            load_we   = ($urandom % 3) == 0;
            load_idx  = 8'($urandom % 16);
            load_data = $urandom;
            case ($urandom % 8)
                0, 1, 2, 3: a = 64'(($urandom % 16) * 4);
                4:          a = 64'($urandom % (DEPTH * 4));
                5:          a = 64'(($urandom % 16) * 4 + ($urandom % 4));
                6:          a = {$urandom, $urandom};
                default:    a = 64'(DEPTH * 4 + ($urandom % 64));
            endcase
            req_addr = a;
            tick();
        end
        req_valid = 1'b0; load_we = 1'b0; rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset while a response is stalled; program contents are swept away.
        for (int i = 0; i < 4; i++) load(8'(i), prog[i]);
        rsp_ready = 1'b0;
        fetch(64'd4);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rst_stall_valid", rsp_valid, 0);
        check("rst_stall_busy", busy, 1);
        tick();
        reset = 1'b0; rsp_ready = 1'b1;
        fetch(64'd0);
        for (int i = 1; i < 4; i++) fetch(64'(i * 4));
        @(negedge clk);
        check("resweep_nop", rsp_instr, NOP);
        tick();

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the single-cycle/pipelined core fetch stage. It replaces the combinational ROM-style instruction store with:
- a registered read port using a valid/ready handshake;
- a program-load write port;
- hardware clear-to-NOP after reset;
- out-of-range and misalignment fault reporting.

It sits between the PC/fetch logic and the decode stage.

## Interface
- ADDR_W, 64, byte-address width of `req_addr`
- INSTR_W, 32, instruction word width
- DEPTH, 256, number of instruction words (power of two, ≥4)
- NOP_WORD, 32'h00000013, fill value and fault response (RISC-V `addi x0,x0,0`)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  fetch request present
- req_ready  output  1  block accepts a request this cycle
- req_addr  input  ADDR_W  byte address of the instruction
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer takes the response
- rsp_instr  output  INSTR_W  fetched instruction
- rsp_fault  output  2  bit0 = misaligned, bit1 = out of range
- load_we  input  1  program-load write strobe
- load_idx  input  $clog2(DEPTH)  word index to write
- load_data  input  INSTR_W  word to write
- busy  output  1  init sweep in progress

## Operation
- FSM has two states, INIT and RUN.
  - `reset` forces INIT with the clear counter at 0.
  - INIT writes NOP_WORD to word `cnt` each cycle and increments `cnt`.
  - After writing word DEPTH-1, the FSM moves to RUN. This takes exactly DEPTH cycles.
- INIT behaviour: `busy`=1, `req_ready`=0, `load_we` ignored.
- RUN behaviour: `busy`=0.
- `req_ready` = RUN && (!rsp_valid || rsp_ready). A request is accepted when req_valid && req_ready.
- Address decode on accept:
  - word index = req_addr[ADDR_W-1:2].
  - out_of_range = (req_addr[ADDR_W-1:2] >= DEPTH), compared over the full upper field with no truncation.
- Out-of-range response: rsp_instr = NOP_WORD, rsp_fault[1] = 1, memory not read.
- Load port (RUN only): on `load_we`, mem[load_idx] <= load_data. The load port has no handshake and always succeeds.
- Same-cycle load and accepted fetch to the same word: response returns `load_data` (write-first bypass).
- Response register:
  - Loaded on accept.
  - Held unchanged (instr, fault, valid) while rsp_valid && !rsp_ready.
  - Cleared (rsp_valid <= 0) when rsp_ready with no new accept.
- Simultaneous events: a drain and a new accept in the same cycle give back-to-back responses with no bubble.
- Reset values: rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=0, req_ready=0, busy=1.
- Reset asserted mid-INIT or mid-RUN:
  - Restarts INIT from word 0 and discards any pending response.
  - Loaded program contents are overwritten by the sweep.

## Timing
- Read latency 1 cycle: request accepted at edge N, rsp_valid/rsp_instr valid after edge N (sampled at N+1).
- Throughput 1 fetch/cycle while rsp_ready=1.
- First possible accept: cycle DEPTH after reset deassertion (DEPTH cycles of busy=1).
- A load write at edge N is visible to a fetch accepted at edge N (bypass) and at any later edge.
- No combinational path from req_* to rsp_*. The only combinational input-to-output path is rsp_ready → req_ready.

## Configuration
- IMEM_MISALIGN_TRAP_EN defined:
  - An accepted request with req_addr[1:0] != 0 returns NOP_WORD with rsp_fault[0]=1.
  - If the address is also out of range, both fault bits are set.
- IMEM_MISALIGN_TRAP_EN undefined:
  - req_addr[1:0] is ignored; the address floors to the word, e.g. address 2 returns word 0.
  - rsp_fault[0] is tied to 0.

## Test plan
- Reset, then hold req_valid=1 → busy=1 and req_ready=0 for exactly 256 cycles; the first response at addr 0 is 32'h00000013 with fault 0.
- Load idx 0..3 with 32'h00700013, 32'h07600993, 32'h00100593, 32'h00B98B33, then fetch addr 0,4,8,12 back-to-back with rsp_ready=1 → the four words on 4 consecutive cycles, no bubbles.
- Fetch addr 4 with rsp_ready=0 for 3 cycles → rsp_instr stays 32'h07600993, req_ready=0; on rsp_ready=1 the next request is accepted the same cycle.
- Same cycle: load idx 10 = 32'h00D50663 and fetch addr 40 → response 32'h00D50663.
- Fetch addr 1024 → NOP_WORD with rsp_fault=2'b10. Fetch addr 2 → with the macro: NOP_WORD, fault 2'b01; without the macro: word 0, fault 0.
- Assert reset during a stalled response → rsp_valid=0 next cycle, busy=1, and previously loaded words read back as NOP after the re-sweep.
